// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Fetch-side PC sequencer. Owns the fetch PC, steps it by 4 on each accepted
//   fetch, redirects to resolved taken-branch targets with a multi-cycle IF/ID
//   flush, and traps on misaligned targets.
//
// Optional feature macro: BRANCH_STATS_EN
//   defined   : br_count / br_taken_count are saturating 32-bit counters
//   undefined : both ports are tied to zero and no counter flops exist
//
// Ports
//   clk            in   system clock, rising edge
//   rstn           in   asynchronous active-low reset
//   stall          in   hazard stall, PC held while high
//   br_valid       in   execute stage presents a resolved branch
//   br_taken       in   branch outcome, qualified by br_valid
//   br_target      in   redirect target (npc from the address calculator)
//   fetch_ready    in   instruction memory accepts pc_out this cycle
//   pc_out         out  current fetch address
//   pc_valid       out  pc_out is a fetch request
//   flush          out  clear IF/ID pipeline registers
//   halted         out  misaligned-target trap taken
//   br_count       out  resolved-branch counter
//   br_taken_count out  taken-branch counter
//
// State table
//   state | meaning
//   BOOT  | first cycle after reset release, no fetch issued
//   FETCH | sequential fetch, pc_valid high
//   FLUSH | redirect in progress, flush high for FlushDepth cycles
//   HALT  | misaligned target trapped, left only by reset

module branch_redirect_ctrl #(
  parameter int                     WordSize    = 32,
  parameter logic [WordSize-1:0]    ResetVector = '0,
  parameter int                     FlushDepth  = 2    // legal range 1..15
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                br_valid,
  input  logic                br_taken,
  input  logic [WordSize-1:0] br_target,
  input  logic                fetch_ready,
  output logic [WordSize-1:0] pc_out,
  output logic                pc_valid,
  output logic                flush,
  output logic                halted,
  output logic [31:0]         br_count,
  output logic [31:0]         br_taken_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] FlushLoad = 4'(FlushDepth);

  state_t              state_q, state_d;
  logic [WordSize-1:0] pc_q, pc_d;
  logic [3:0]          flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= BOOT;
      pc_q        <= ResetVector;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        // A taken redirect wins over stall; a misaligned one traps and leaves
        // the PC at the last sequential address.
        if (br_valid && br_taken) begin
          if (br_target[1:0] != 2'b00) begin
            state_d = HALT;
          end else begin
            pc_d        = br_target;
            flush_cnt_d = FlushLoad;
            state_d     = FLUSH;
          end
        end else if (!stall && fetch_ready) begin
          pc_d = pc_q + WordSize'(4);
        end
      end
      FLUSH: begin
        // Loaded with FlushDepth, leaves on the cycle it reads 1, giving
        // exactly FlushDepth flush cycles.
        if (flush_cnt_q <= 4'd1) begin
          flush_cnt_d = '0;
          state_d     = FETCH;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Outputs come from registered state and PC only.
  assign pc_out   = pc_q;
  assign pc_valid = (state_q == FETCH);
  assign flush    = (state_q == FLUSH) || (state_q == HALT);
  assign halted   = (state_q == HALT);

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] tk_cnt_q;
  logic        stat_en;

  assign stat_en = br_valid && ((state_q == FETCH) || (state_q == FLUSH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      if (stat_en && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_q <= br_cnt_q + 32'd1;
      if (stat_en && br_taken && (tk_cnt_q != 32'hFFFF_FFFF)) tk_cnt_q <= tk_cnt_q + 32'd1;
    end
  end

  assign br_count       = br_cnt_q;
  assign br_taken_count = tk_cnt_q;
`else
  assign br_count       = '0;
  assign br_taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  localparam logic [31:0] RV = 32'h0000_0100;
`ifdef BRANCH_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic        clk, rstn, stall, br_valid, br_taken, fetch_ready;
  logic [31:0] br_target, pc_out, br_count, br_taken_count;
  logic        pc_valid, flush, halted;

  branch_redirect_ctrl #(
    .WordSize(32), .ResetVector(RV), .FlushDepth(2)
  ) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .br_valid(br_valid),
    .br_taken(br_taken), .br_target(br_target), .fetch_ready(fetch_ready),
    .pc_out(pc_out), .pc_valid(pc_valid), .flush(flush), .halted(halted),
    .br_count(br_count), .br_taken_count(br_taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic s, bv, bt; logic [31:0] tgt; logic fr;
    logic [31:0] pc; logic v, f, h;
  } row_t;
  typedef struct { logic [31:0] pc; logic v, f, h; } exp_t;

  exp_t        exp_q[$];
  row_t        rows[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_tk = 0;
  logic        active = 1'b0;

  function automatic row_t mk(input logic s, bv, bt, input logic [31:0] tgt, input logic fr,
                              input logic [31:0] pc, input logic v, f, h);
    row_t r;
    r.s = s; r.bv = bv; r.bt = bt; r.tgt = tgt; r.fr = fr;
    r.pc = pc; r.v = v; r.f = f; r.h = h;
    return r;
  endfunction

  task automatic cyc(input row_t r);
    stall = r.s; br_valid = r.bv; br_taken = r.bt; br_target = r.tgt; fetch_ready = r.fr;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_br = 0; exp_tk = 0; active = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rstn = 1'b0; stall = 0; br_valid = 0; br_taken = 0; br_target = 0; fetch_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc_out !== RV || pc_valid !== 1'b0 || flush !== 1'b0 || halted !== 1'b0 ||
        br_count !== 32'd0 || br_taken_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got pc=%h v=%b f=%b h=%b bc=%0d tc=%0d, expected pc=%h v=0 f=0 h=0 bc=0 tc=0",
               pc_out, pc_valid, flush, halted, br_count, br_taken_count, RV);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (pc_valid !== 1'b0 || pc_out !== RV) begin
      errors++;
      $display("FAIL boot_cycle: got pc=%h v=%b, expected pc=%h v=0", pc_out, pc_valid, RV);
    end
    rows = '{};
    rows.push_back(mk(0,0,0,0,1, 32'h100,1,0,0));
    rows.push_back(mk(0,0,0,0,1, 32'h104,1,0,0));
    rows.push_back(mk(0,0,0,0,1, 32'h108,1,0,0));
    foreach (rows[i]) begin
      if (active && rows[i].bv) begin exp_br++; if (rows[i].bt) exp_tk++; end
      exp_q.push_back('{rows[i].pc, rows[i].v, rows[i].f, rows[i].h});
      cyc(rows[i]);
      e = exp_q.pop_front();
      active = e.v || (e.f && !e.h);
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || flush !== e.f || halted !== e.h) begin
        errors++;
        $display("FAIL reset_seq[%0d]: got pc=%h v=%b f=%b h=%b, expected pc=%h v=%b f=%b h=%b",
                 i, pc_out, pc_valid, flush, halted, e.pc, e.v, e.f, e.h);
      end
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    rows = '{};
    rows.push_back(mk(0,1,1,32'h200,1, 32'h200,0,1,0));
    rows.push_back(mk(0,1,0,32'h300,1, 32'h200,0,1,0));
    rows.push_back(mk(0,0,0,0,1,       32'h200,1,0,0));
    rows.push_back(mk(0,0,0,0,1,       32'h204,1,0,0));
    foreach (rows[i]) begin
      if (active && rows[i].bv) begin exp_br++; if (rows[i].bt) exp_tk++; end
      exp_q.push_back('{rows[i].pc, rows[i].v, rows[i].f, rows[i].h});
      cyc(rows[i]);
      e = exp_q.pop_front();
      active = e.v || (e.f && !e.h);
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || flush !== e.f || halted !== e.h) begin
        errors++;
        $display("FAIL redirect[%0d]: got pc=%h v=%b f=%b h=%b, expected pc=%h v=%b f=%b h=%b",
                 i, pc_out, pc_valid, flush, halted, e.pc, e.v, e.f, e.h);
      end
    end
    checks++;
    if (br_count !== (StatsOn ? exp_br : 32'd0) || br_taken_count !== (StatsOn ? exp_tk : 32'd0)) begin
      errors++;
      $display("FAIL redirect_stats: got bc=%0d tc=%0d, expected bc=%0d tc=%0d", br_count, br_taken_count,
               StatsOn ? exp_br : 32'd0, StatsOn ? exp_tk : 32'd0);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    rows = '{};
    rows.push_back(mk(1,0,0,0,1,      32'h204,1,0,0));
    rows.push_back(mk(1,0,0,0,1,      32'h204,1,0,0));
    rows.push_back(mk(1,1,1,32'h40,1, 32'h040,0,1,0));
    rows.push_back(mk(1,0,0,0,1,      32'h040,0,1,0));
    rows.push_back(mk(0,0,0,0,1,      32'h040,1,0,0));
    rows.push_back(mk(0,0,0,0,1,      32'h044,1,0,0));
    foreach (rows[i]) begin
      if (active && rows[i].bv) begin exp_br++; if (rows[i].bt) exp_tk++; end
      exp_q.push_back('{rows[i].pc, rows[i].v, rows[i].f, rows[i].h});
      cyc(rows[i]);
      e = exp_q.pop_front();
      active = e.v || (e.f && !e.h);
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || flush !== e.f || halted !== e.h) begin
        errors++;
        $display("FAIL stall[%0d]: got pc=%h v=%b f=%b h=%b, expected pc=%h v=%b f=%b h=%b",
                 i, pc_out, pc_valid, flush, halted, e.pc, e.v, e.f, e.h);
      end
    end
  endtask

  task automatic test_not_taken_wrap();
    exp_t e;
    rows = '{};
    rows.push_back(mk(0,1,0,32'h300,1,       32'h048,1,0,0));
    rows.push_back(mk(0,1,0,32'h300,0,       32'h048,1,0,0));
    rows.push_back(mk(0,0,0,0,1,             32'h04c,1,0,0));
    rows.push_back(mk(0,1,1,32'hFFFFFFFC,0,  32'hFFFFFFFC,0,1,0));
    rows.push_back(mk(0,0,0,0,0,             32'hFFFFFFFC,0,1,0));
    rows.push_back(mk(0,0,0,0,0,             32'hFFFFFFFC,1,0,0));
    rows.push_back(mk(0,0,0,0,1,             32'h00000000,1,0,0));
    rows.push_back(mk(0,0,0,0,1,             32'h00000004,1,0,0));
    foreach (rows[i]) begin
      if (active && rows[i].bv) begin exp_br++; if (rows[i].bt) exp_tk++; end
      exp_q.push_back('{rows[i].pc, rows[i].v, rows[i].f, rows[i].h});
      cyc(rows[i]);
      e = exp_q.pop_front();
      active = e.v || (e.f && !e.h);
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || flush !== e.f || halted !== e.h) begin
        errors++;
        $display("FAIL nt_wrap[%0d]: got pc=%h v=%b f=%b h=%b, expected pc=%h v=%b f=%b h=%b",
                 i, pc_out, pc_valid, flush, halted, e.pc, e.v, e.f, e.h);
      end
    end
    checks++;
    if (br_count !== (StatsOn ? exp_br : 32'd0) || br_taken_count !== (StatsOn ? exp_tk : 32'd0)) begin
      errors++;
      $display("FAIL nt_wrap_stats: got bc=%0d tc=%0d, expected bc=%0d tc=%0d", br_count, br_taken_count,
               StatsOn ? exp_br : 32'd0, StatsOn ? exp_tk : 32'd0);
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    rows = '{};
    rows.push_back(mk(0,0,0,0,1,       32'h008,1,0,0));
    rows.push_back(mk(0,1,1,32'h202,1, 32'h008,0,1,1));
    for (int k = 0; k < 22; k++)
      rows.push_back(mk(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                        $urandom & 32'hFFFF_FFFC, 1'($urandom_range(1)), 32'h008,0,1,1));
    foreach (rows[i]) begin
      if (active && rows[i].bv) begin exp_br++; if (rows[i].bt) exp_tk++; end
      exp_q.push_back('{rows[i].pc, rows[i].v, rows[i].f, rows[i].h});
      cyc(rows[i]);
      e = exp_q.pop_front();
      active = e.v || (e.f && !e.h);
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || flush !== e.f || halted !== e.h) begin
        errors++;
        $display("FAIL misaligned[%0d]: got pc=%h v=%b f=%b h=%b, expected pc=%h v=%b f=%b h=%b",
                 i, pc_out, pc_valid, flush, halted, e.pc, e.v, e.f, e.h);
      end
    end
    checks++;
    if (br_count !== (StatsOn ? exp_br : 32'd0) || br_taken_count !== (StatsOn ? exp_tk : 32'd0)) begin
      errors++;
      $display("FAIL halt_stats: got bc=%0d tc=%0d, expected bc=%0d tc=%0d", br_count, br_taken_count,
               StatsOn ? exp_br : 32'd0, StatsOn ? exp_tk : 32'd0);
    end
    rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pc_out !== RV || pc_valid !== 1'b0 || flush !== 1'b0 || halted !== 1'b0 ||
        br_count !== 32'd0 || br_taken_count !== 32'd0) begin
      errors++;
      $display("FAIL halt_reset: got pc=%h v=%b f=%b h=%b bc=%0d tc=%0d, expected pc=%h v=0 f=0 h=0 bc=0 tc=0",
               pc_out, pc_valid, flush, halted, br_count, br_taken_count, RV);
    end
    stall = 0; br_valid = 0; br_taken = 0; fetch_ready = 1;
    @(negedge clk);
    rstn = 1'b1;
    rows = '{};
    rows.push_back(mk(0,0,0,0,1, 32'h100,1,0,0));
    rows.push_back(mk(0,0,0,0,1, 32'h104,1,0,0));
    foreach (rows[i]) begin
      if (active && rows[i].bv) begin exp_br++; if (rows[i].bt) exp_tk++; end
      exp_q.push_back('{rows[i].pc, rows[i].v, rows[i].f, rows[i].h});
      cyc(rows[i]);
      e = exp_q.pop_front();
      active = e.v || (e.f && !e.h);
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || flush !== e.f || halted !== e.h) begin
        errors++;
        $display("FAIL halt_reboot[%0d]: got pc=%h v=%b f=%b h=%b, expected pc=%h v=%b f=%b h=%b",
                 i, pc_out, pc_valid, flush, halted, e.pc, e.v, e.f, e.h);
      end
    end
  endtask

  task automatic test_async_mid_flush();
    exp_t e;
    rows = '{};
    rows.push_back(mk(0,1,1,32'h500,1, 32'h500,0,1,0));
    rows.push_back(mk(0,1,0,32'h0,1,   32'h500,0,1,0));
    foreach (rows[i]) begin
      if (active && rows[i].bv) begin exp_br++; if (rows[i].bt) exp_tk++; end
      exp_q.push_back('{rows[i].pc, rows[i].v, rows[i].f, rows[i].h});
      cyc(rows[i]);
      e = exp_q.pop_front();
      active = e.v || (e.f && !e.h);
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || flush !== e.f || halted !== e.h) begin
        errors++;
        $display("FAIL mid_flush[%0d]: got pc=%h v=%b f=%b h=%b, expected pc=%h v=%b f=%b h=%b",
                 i, pc_out, pc_valid, flush, halted, e.pc, e.v, e.f, e.h);
      end
    end
    checks++;
    if (br_count !== (StatsOn ? exp_br : 32'd0) || br_taken_count !== (StatsOn ? exp_tk : 32'd0)) begin
      errors++;
      $display("FAIL mid_flush_stats: got bc=%0d tc=%0d, expected bc=%0d tc=%0d", br_count, br_taken_count,
               StatsOn ? exp_br : 32'd0, StatsOn ? exp_tk : 32'd0);
    end
    // Second flush cycle, well away from any clock edge.
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pc_out !== RV || pc_valid !== 1'b0 || flush !== 1'b0 || halted !== 1'b0 ||
        br_count !== 32'd0 || br_taken_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got pc=%h v=%b f=%b h=%b bc=%0d tc=%0d, expected pc=%h v=0 f=0 h=0 bc=0 tc=0",
               pc_out, pc_valid, flush, halted, br_count, br_taken_count, RV);
    end
    stall = 0; br_valid = 0; br_taken = 0; fetch_ready = 1;
    @(negedge clk);
    rstn = 1'b1;
    rows = '{};
    rows.push_back(mk(0,0,0,0,1, 32'h100,1,0,0));
    rows.push_back(mk(0,0,0,0,1, 32'h104,1,0,0));
    foreach (rows[i]) begin
      if (active && rows[i].bv) begin exp_br++; if (rows[i].bt) exp_tk++; end
      exp_q.push_back('{rows[i].pc, rows[i].v, rows[i].f, rows[i].h});
      cyc(rows[i]);
      e = exp_q.pop_front();
      active = e.v || (e.f && !e.h);
      checks++;
      if (pc_out !== e.pc || pc_valid !== e.v || flush !== e.f || halted !== e.h) begin
        errors++;
        $display("FAIL async_reboot[%0d]: got pc=%h v=%b f=%b h=%b, expected pc=%h v=%b f=%b h=%b",
                 i, pc_out, pc_valid, flush, halted, e.pc, e.v, e.f, e.h);
      end
    end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall();
    test_not_taken_wrap();
    test_misaligned();
    test_async_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
